fetch_controller: RTL

- Sequences the core's instruction memory.
- Owns the fetch PC and drives the word address into the asynchronous-read instruction memory.
- Captures each returned 32-bit instruction with its PC into a 2-entry prefetch buffer, handed to decode over a valid/ready handshake.
- Handles start, redirect (branch/jump), EBREAK halt and out-of-range/misaligned fetch faults.

---
 rtl/fetch_if.sv | 49 ++++
 rtl/fetch_controller.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/fetch_if.sv
// Fetch-side bundle: control inputs, instruction memory port and the decode handshake.
// The master modport is the fetch controller; slave is the core/memory side.
interface fetch_if #(
  parameter int unsigned WORDSIZE         = 64,
  parameter int unsigned INSTRUCTION_SIZE = 32
);
  logic                        start;
  logic                        redirect_valid;
  logic [WORDSIZE-1:0]         redirect_pc;
  logic [WORDSIZE-1:0]         imem_addr;
  logic [INSTRUCTION_SIZE-1:0] imem_instruction;
  logic                        out_valid;
  logic                        out_ready;
  logic [INSTRUCTION_SIZE-1:0] out_instruction;
  logic [WORDSIZE-1:0]         out_pc;
  logic                        busy;
  logic                        halted;
  logic                        fault;

  modport master (
    input  start,
    input  redirect_valid,
    input  redirect_pc,
    input  imem_instruction,
    input  out_ready,
    output imem_addr,
    output out_valid,
    output out_instruction,
    output out_pc,
    output busy,
    output halted,
    output fault
  );

  modport slave (
    output start,
    output redirect_valid,
    output redirect_pc,
    output imem_instruction,
    output out_ready,
    input  imem_addr,
    input  out_valid,
    input  out_instruction,
    input  out_pc,
    input  busy,
    input  halted,
    input  fault
  );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the fetch PC, reads an async instruction memory and
// queues {instruction, pc} pairs in a 2-entry prefetch buffer for decode.
module fetch_controller #(
  parameter int unsigned         WORDSIZE         = 64,
  parameter int unsigned         INSTRUCTION_SIZE = 32,
  parameter int unsigned         MEMORY_SIZE      = 1024,
  parameter logic [WORDSIZE-1:0] RESET_PC         = '0
) (
  input logic      clk,
  input logic      rst_n,
  fetch_if.master  bus
);

  localparam logic [INSTRUCTION_SIZE-1:0] Ebreak = INSTRUCTION_SIZE'(32'h0010_0073);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHalt
  } state_e;

  state_e                      state_q, state_d;
  logic [WORDSIZE-1:0]         fetch_pc_q, fetch_pc_d;
  logic                        fault_q, fault_d;
  logic [1:0]                  count_q, count_d;
  logic [INSTRUCTION_SIZE-1:0] instr_q [2];
  logic [INSTRUCTION_SIZE-1:0] instr_d [2];
  logic [WORDSIZE-1:0]         pc_q [2];
  logic [WORDSIZE-1:0]         pc_d [2];

  logic pop;
  logic push;
  logic flush;
  logic fetch_ok;
  logic wr_slot;

  assign pop      = (count_q != 2'd0) & bus.out_ready;
  assign fetch_ok = (fetch_pc_q[1:0] == 2'b00) &&
                    ((fetch_pc_q >> 2) < WORDSIZE'(MEMORY_SIZE));

  // Control: start beats redirect, redirect beats fault/push/EBREAK.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    fault_d    = fault_q;
    push       = 1'b0;
    flush      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d    = StRun;
          fetch_pc_d = RESET_PC;
          flush      = 1'b1;
        end
      end
      StRun: begin
        if (bus.start) begin
          fetch_pc_d = RESET_PC;
          flush      = 1'b1;
        end else if (bus.redirect_valid) begin
          fetch_pc_d = bus.redirect_pc;
          flush      = 1'b1;
        end else if (!fetch_ok) begin
          state_d = StHalt;
          fault_d = 1'b1;
        end else if ((count_q != 2'd2) || pop) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + WORDSIZE'(4);
          if (bus.imem_instruction == Ebreak) begin
            state_d = StHalt;
          end
        end
      end
      StHalt: begin
        if (bus.start) begin
          state_d    = StRun;
          fetch_pc_d = RESET_PC;
          fault_d    = 1'b0;
          flush      = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Slot 0 is always the head; a push lands in the first slot free after this cycle's pop.
  assign wr_slot = (count_q == 2'd2) | ((count_q == 2'd1) & ~pop);

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      if (pop) begin
        instr_d[0] = instr_q[1];
        pc_d[0]    = pc_q[1];
      end
      if (push) begin
        instr_d[wr_slot] = bus.imem_instruction;
        pc_d[wr_slot]    = fetch_pc_q;
      end
      count_d = count_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      fault_q    <= 1'b0;
      count_q    <= 2'd0;
      instr_q[0] <= '0;
      instr_q[1] <= '0;
      pc_q[0]    <= '0;
      pc_q[1]    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      fault_q    <= fault_d;
      count_q    <= count_d;
      instr_q[0] <= instr_d[0];
      instr_q[1] <= instr_d[1];
      pc_q[0]    <= pc_d[0];
      pc_q[1]    <= pc_d[1];
    end
  end

  assign bus.imem_addr       = fetch_pc_q >> 2;
  assign bus.out_valid       = (count_q != 2'd0);
  assign bus.out_instruction = instr_q[0];
  assign bus.out_pc          = pc_q[0];
  assign bus.busy            = (state_q == StRun);
  assign bus.halted          = (state_q == StHalt);
  assign bus.fault           = fault_q;

endmodule
